led_fader: RTL
==============

# led_fader

Downstream LED output stage: takes the 8 raw on/off LED requests produced by the blink generators, which run on the ADC clock, and drives the board LED pins with PWM-dimmed outputs. Each request edge is turned into a linear brightness fade-in or fade-out rather than a hard step. A bypass mode passes requests straight through for debug.

## Interface
- CLOCK_FREQ_HZ, 122_880_000: ADC clock frequency. Informational only; it does not change the logic.
- N_LED, 8: number of channels.
- STEP_CYCLES, 120_000: clock cycles per brightness step.
  - Default full fade (255 steps) ≈ 249 ms.
  - Minimum value is 1.
- adc_clk_i, input, 1: ADC-domain clock. All logic runs on its rising edge.
- adc_rstn_i, input, 1: reset, asynchronous, active-low.
- led_req_i, input, N_LED: per-LED on request. Same clock domain, level-sensitive.
- bypass_i, input, 1: 1 = led_o follows the registered request with no fading.
- led_o, output, N_LED: PWM-modulated LED drive, registered.
- busy_o, output, 1: 1 while any channel is mid-fade, registered.

## Operation
- Request register: r_req <= led_req_i every cycle.
- Step prescaler:
  - Counter pre runs 0..STEP_CYCLES-1 and wraps to 0.
  - tick = 1 for exactly one cycle, when pre == STEP_CYCLES-1.
  - With STEP_CYCLES=1, tick is 1 every cycle.
- PWM counter: p (8 bit) counts 0..254 and wraps to 0. Period is 255 cycles. It never takes the value 255.
- Per-channel level L[i] (8 bit, saturating, never wraps). Its state is decoded from L and r_req:
  - OFF: L=0, r_req=0. L holds.
  - RISE: r_req=1, L<255. L <= L+1 on tick.
  - ON: L=255, r_req=1. L holds.
  - FALL: r_req=0, L>0. L <= L-1 on tick.
- Request reversal mid-fade: direction changes at the next tick. L has no jump; it continues from its current value.
- Output in normal mode: led_o[i] <= (p < L[i]).
  - L=0 gives constant 0.
  - L=255 gives constant 1.
  - L=k gives k high cycles per 255.
- Bypass mode (bypass_i=1):
  - led_o[i] <= r_req[i].
  - L[i] is forced to 255 when r_req[i]=1 and to 0 when r_req[i]=0, every cycle.
  - Leaving bypass causes no fade and no glitch.
  - The prescaler and p keep running while in bypass.
- busy_o <= OR over i of (L[i] ≠ (r_req[i] ? 255 : 0)), evaluated on the next-state L. busy_o is always 0 in bypass.
- Widths: pre is $clog2(STEP_CYCLES) bits, with a minimum of 1. All comparisons are unsigned.

## Timing
- Reset (adc_rstn_i=0) takes effect immediately and asynchronously:
  - led_o=0, busy_o=0.
  - L=0, r_req=0, pre=0, p=0.
- Reset deasserted mid-fade: all channels restart from OFF. Nothing is retained.
- Request latency:
  - led_req_i changes before edge t; r_req changes at edge t.
  - busy_o rises at edge t+1.
  - L first changes at the first tick edge after t.
- led_o reflects a new L one edge after L updates.
- Full fade 0→255 or 255→0 takes exactly 255 ticks, i.e. 255·STEP_CYCLES cycles.
- Bypass latency: led_req_i to led_o is 2 edges.
- A change on bypass_i takes effect at the next edge.
- Simultaneous tick and request change on the same edge: the tick acts on the old r_req. The new direction applies from the following tick.

## Test plan
- Reset: assert adc_rstn_i mid-fade with L≈100 → led_o=0 and busy_o=0 immediately. After release, L=0 and led_o stays 0 with led_req_i=0.
- Fade-in, STEP_CYCLES=4: led_req_i[0] 0→1 → busy_o=1 two edges later. L[0] reaches 255 after 1020 cycles (±4). busy_o then drops and led_o[0] is constant 1.
- PWM duty, STEP_CYCLES=4: freeze L[0]=64 by toggling the request at the right tick → led_o[0] is high for exactly 64 of every 255 cycles. Also check L=0 (never high) and L=255 (never low).
- Reversal: request 1 until L=128, then 0 → L decreases 128→127… with no jump, and reaches 0 after 128 ticks.
- Bypass: bypass_i=1, led_req_i=8'hA5 → led_o=8'hA5 exactly 2 edges later, busy_o=0. Drop bypass_i → led_o stays duty-equivalent (255/0), with no fade.
- Multichannel/simultaneous: set all 8 requests at once, then clear channel 3 on a tick edge → channel 3 reverses on the following tick, the others continue independently, and busy_o stays 1 until the last channel settles.

Source files
------------

// File: rtl/led_fader.sv
`default_nettype none
// ============================================================================
// led_fader : PWM LED output stage with linear fade-in/fade-out and bypass
// Revision  : 1.0
// ============================================================================
module led_fader #(
  parameter int CLOCK_FREQ_HZ = 122_880_000,
  parameter int N_LED         = 8,
  parameter int STEP_CYCLES   = 120_000
) (
  input  logic             adc_clk_i,
  input  logic             adc_rstn_i,
  input  logic [N_LED-1:0] led_req_i,
  input  logic             bypass_i,
  output logic [N_LED-1:0] led_o,
  output logic             busy_o
);

  localparam int              PRE_W   = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(STEP_CYCLES - 1);
  localparam logic [7:0]      P_MAX   = 8'd254;
  localparam logic [7:0]      L_MAX   = 8'd255;
  localparam logic [7:0]      L_MIN   = 8'd0;

  if (CLOCK_FREQ_HZ < 1 || STEP_CYCLES < 1) begin : g_bad_params
    $error("led_fader: CLOCK_FREQ_HZ and STEP_CYCLES must be positive");
  end

  logic [N_LED-1:0] req_q, req_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [7:0]       p_q, p_d;
  logic [N_LED-1:0] led_q, led_d;
  logic             busy_q, busy_d;
  logic             tick;
  logic [N_LED-1:0] pwm_hi;
  logic [N_LED-1:0] unsettled;

  always_comb begin
    req_d  = led_req_i;
    tick   = (pre_q == PRE_MAX);
    pre_d  = tick ? '0 : pre_q + PRE_W'(1);
    // p never reaches 255, so a level of 255 keeps the output solidly on
    p_d    = (p_q == P_MAX) ? 8'd0 : p_q + 8'd1;
    led_d  = bypass_i ? req_q : pwm_hi;
    busy_d = ~bypass_i & (|unsettled);
  end

  for (genvar i = 0; i < N_LED; i++) begin : g_ch
    logic [7:0] lvl_q, lvl_d;

    // Steps use the request registered before this edge, so a request change
    // coinciding with a tick only redirects the following tick.
    always_comb begin
      lvl_d = lvl_q;
      if (bypass_i) begin
        lvl_d = req_q[i] ? L_MAX : L_MIN;
      end else if (tick) begin
        if (req_q[i] && (lvl_q != L_MAX)) begin
          lvl_d = lvl_q + 8'd1;
        end else if (!req_q[i] && (lvl_q != L_MIN)) begin
          lvl_d = lvl_q - 8'd1;
        end
      end
    end

    always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
      if (!adc_rstn_i) begin
        lvl_q <= L_MIN;
      end else begin
        lvl_q <= lvl_d;
      end
    end

    assign pwm_hi[i]    = (p_q < lvl_q);
    assign unsettled[i] = (lvl_d != (req_q[i] ? L_MAX : L_MIN));
  end

  always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
    if (!adc_rstn_i) begin
      req_q  <= '0;
      pre_q  <= '0;
      p_q    <= 8'd0;
      led_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      req_q  <= req_d;
      pre_q  <= pre_d;
      p_q    <= p_d;
      led_q  <= led_d;
      busy_q <= busy_d;
    end
  end

  assign led_o  = led_q;
  assign busy_o = busy_q;

endmodule
`default_nettype wire
